// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: source-select codes, map entry layout and FSM state types for the input mapper.
package arcade_input_pkg;
  localparam logic [6:0] SRC_ZERO     = 7'd0;
  localparam logic [6:0] SRC_ONE      = 7'd1;
  localparam logic [6:0] SRC_JOY_BASE = 7'd2;
  localparam logic [6:0] SRC_COIN     = 7'd34;
  localparam logic [6:0] SRC_START    = 7'd35;
  localparam logic [6:0] SRC_FIRE     = 7'd36;
  localparam logic [6:0] SRC_DIP_BASE = 7'd64;
  typedef struct packed {
    logic       invert;
    logic [6:0] sel;
  } map_entry_t;
  typedef enum logic [1:0] {COIN_IDLE, COIN_PULSE, COIN_LOCK} coin_state_e;
  typedef enum logic [1:0] {SCAN_IDLE, SCAN_RUN, SCAN_COMMIT} scan_state_e;
endpackage

// File: rtl/arcade_coin_conditioner.sv
// arcade_coin_conditioner: turns any coin rising edge into a fixed-width pulse followed by a lockout.
module arcade_coin_conditioner import arcade_input_pkg::*; #(
  parameter int          NUM_COINS = 4,
  parameter logic [15:0] PULSE_CYC = 16'd2000,
  parameter logic [15:0] LOCK_CYC  = 16'd8000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] coin_in,
  output logic                 coin_pulse
);
  coin_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [NUM_COINS-1:0] prev_q;
  logic rise;
  assign rise = |(coin_in & ~prev_q);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COIN_IDLE;
      cnt_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= coin_in;
    end
  end
  // LOCK holds its count once expired and only leaves when every coin line is released
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    case (state_q)
      COIN_IDLE: begin
        cnt_d   = '0;
        state_d = rise ? COIN_PULSE : COIN_IDLE;
      end
      COIN_PULSE: if (cnt_q == PULSE_CYC - 16'd1) begin
        state_d = COIN_LOCK;
        cnt_d   = '0;
      end
      COIN_LOCK: if (cnt_q >= LOCK_CYC - 16'd1) begin
        cnt_d   = cnt_q;
        state_d = |coin_in ? COIN_LOCK : COIN_IDLE;
      end
      default: state_d = COIN_IDLE;
    endcase
  end
  assign coin_pulse = state_q == COIN_PULSE;
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: ioctl-loaded DIP/mode/bit-map tables driving active-low CPU input ports.
// Define ARCADE_INPUT_SOCD_EN to cancel opposing joystick directions before source selection.
module arcade_input_mapper import arcade_input_pkg::*; #(
  parameter int          NUM_PLAYERS    = 4,
  parameter int          NUM_PORTS      = 3,
  parameter int          NUM_MODES      = 4,
  parameter int          NUM_DIP_BYTES  = 8,
  parameter logic [7:0]  DIP_INDEX      = 8'd254,
  parameter logic [7:0]  MODE_INDEX     = 8'd1,
  parameter logic [7:0]  MAP_INDEX      = 8'd2,
  parameter logic [15:0] COIN_PULSE_CYC = 16'd2000,
  parameter logic [15:0] COIN_LOCK_CYC  = 16'd8000,
  localparam int         MODE_W         = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ioctl_wr,
  input  logic [7:0]                 ioctl_index,
  input  logic [24:0]                ioctl_addr,
  input  logic [7:0]                 ioctl_dout,
  input  logic [NUM_PLAYERS*16-1:0]  joystick,
  output logic [MODE_W-1:0]          game_mode,
  output logic [NUM_DIP_BYTES*8-1:0] dip_sw,
  output logic [NUM_PORTS*8-1:0]     in_port,
  output logic                       coin_pulse,
  output logic                       scan_done
);
  localparam int BITS      = NUM_PORTS * 8;
  localparam int MAP_DEPTH = NUM_MODES * BITS;
  localparam int MAP_AW    = $clog2(MAP_DEPTH);
  localparam int IDX_W     = $clog2(BITS + 1);
  logic dip_we, mode_we, map_we, rd_en, bit_v;
  logic [MODE_W-1:0] game_mode_q;
  logic [NUM_DIP_BYTES*8-1:0] dip_q;
  logic [7:0] map_mem [MAP_DEPTH];
  logic [7:0] rd_q;
  logic [MAP_AW-1:0] raddr;
  map_entry_t ent;
  scan_state_e st_q, st_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] shadow_q, shadow_d, port_q, port_d;
  logic done_q, done_d, loaded_q;
  logic [127:0] src;
  logic [NUM_PLAYERS*8-1:0] joy;
  logic [NUM_PLAYERS-1:0] coins;
  logic any_start, any_fire, unused_joy;
  assign dip_we  = ioctl_wr && ioctl_index == DIP_INDEX && ioctl_addr < 25'(NUM_DIP_BYTES);
  assign mode_we = ioctl_wr && ioctl_index == MODE_INDEX;
  assign map_we  = ioctl_wr && ioctl_index == MAP_INDEX && ioctl_addr < 25'(MAP_DEPTH);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      game_mode_q <= '0;
      dip_q       <= '0;
      loaded_q    <= 1'b0;
      st_q        <= SCAN_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '1;
      port_q      <= '1;
      done_q      <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_DIP_BYTES; n++)
        if (dip_we && ioctl_addr == 25'(n)) dip_q[n*8+:8] <= ioctl_dout;
      if (mode_we) game_mode_q <= ioctl_dout[MODE_W-1:0];
      loaded_q <= loaded_q | map_we;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      port_q   <= port_d;
      done_q   <= done_d;
    end
  end
  // Map RAM is deliberately unreset; a read colliding with a write returns the old entry
  assign rd_en = st_q == SCAN_RUN && cnt_q < IDX_W'(BITS);
  assign raddr = MAP_AW'(int'(game_mode_q) * BITS + int'(cnt_q));
  always_ff @(posedge clk) begin
    if (map_we) map_mem[ioctl_addr[MAP_AW-1:0]] <= ioctl_dout;
    if (rd_en) rd_q <= map_mem[raddr];
  end
  always_comb begin
    joy        = '0;
    coins      = '0;
    any_start  = 1'b0;
    any_fire   = 1'b0;
    unused_joy = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      joy[p*8+:8] = joystick[p*16+:8];
`ifdef ARCADE_INPUT_SOCD_EN
      if (&joystick[p*16+:2]) joy[p*8+:2] = 2'b00;
      if (&joystick[p*16+2+:2]) joy[p*8+2+:2] = 2'b00;
`endif
      coins[p]   = joystick[p*16+6];
      any_start  = any_start | joystick[p*16+5];
      any_fire   = any_fire | joystick[p*16+4];
      unused_joy = unused_joy ^ (^joystick[p*16+8+:8]);
    end
    src                                   = '0;
    src[SRC_ONE]                          = 1'b1;
    src[SRC_JOY_BASE +: NUM_PLAYERS*8]    = joy;
    src[SRC_COIN]                         = coin_pulse;
    src[SRC_START]                        = any_start;
    src[SRC_FIRE]                         = any_fire;
    src[SRC_DIP_BASE +: NUM_DIP_BYTES*8]  = dip_q;
  end
  assign ent   = map_entry_t'(rd_q);
  assign bit_v = src[ent.sel] ^ ent.invert;
  // RUN spends one extra cycle draining the last RAM read, giving a BITS+2 refresh period
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    port_d   = port_q;
    done_d   = 1'b0;
    case (st_q)
      SCAN_IDLE: begin
        st_d  = SCAN_RUN;
        cnt_d = '0;
      end
      SCAN_RUN: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q != '0) shadow_d[cnt_q - IDX_W'(1)] = ~bit_v;
        st_d = (cnt_q == IDX_W'(BITS)) ? SCAN_COMMIT : SCAN_RUN;
      end
      SCAN_COMMIT: begin
        st_d   = SCAN_RUN;
        cnt_d  = '0;
        port_d = loaded_q ? shadow_q : '1;
        done_d = 1'b1;
      end
      default: st_d = SCAN_IDLE;
    endcase
  end
  arcade_coin_conditioner #(
    .NUM_COINS(NUM_PLAYERS),
    .PULSE_CYC(COIN_PULSE_CYC),
    .LOCK_CYC (COIN_LOCK_CYC)
  ) u_coin (
    .clk       (clk),
    .reset     (reset),
    .coin_in   (coins),
    .coin_pulse(coin_pulse)
  );
  assign game_mode = game_mode_q;
  assign dip_sw    = dip_q;
  assign in_port   = port_q;
  assign scan_done = done_q;
endmodule
